reg_file_sb: RTL and testbench



---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_read_port.sv | 42 ++++
 rtl/reg_file_sb.sv | 122 ++++++++++++
 tb/tb_reg_file_sb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults, typedefs and MIPS register index constants for the
// scoreboarded register file.
package reg_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_word_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;

  localparam int ZERO_REG = 0;
  localparam int V0       = 2;
  localparam int RA       = 31;

endpackage

// File: rtl/reg_read_port.sv
// Combinational read port: hardwired zero, write-to-read bypass, and the
// operand-ready flag taken from the busy scoreboard.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS    = 2 ** ADDR_WIDTH,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 1
) (
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs,
  input  logic [NUM_REGS-1:0]                  busy,
  input  logic                                 write_ok,
  input  logic [ADDR_WIDTH-1:0]                write_addr,
  input  logic [DATA_WIDTH-1:0]                data_in,
  output logic [DATA_WIDTH-1:0]                data,
  output logic                                 ready
);

  // Indices at or above NUM_REGS match no loop entry and keep the 0/ready defaults.
  always_comb begin
    data  = '0;
    ready = 1'b1;
    if ((ZERO_REG_EN != 0) && (addr == ADDR_WIDTH'(ZERO_REG))) begin
      data  = '0;
      ready = 1'b1;
    end else if ((BYPASS_EN != 0) && write_ok && (write_addr == addr)) begin
      data  = data_in;
      ready = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == ADDR_WIDTH'(i)) begin
          data  = regs[i];
          ready = ~busy[i];
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with per-register busy scoreboard.
// Optional macro REG_FILE_TRACE_EN adds simulation-only write/claim_err tracing.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS    = 2 ** ADDR_WIDTH,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 1,
  parameter int V0_INDEX    = V0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic                  ready_a,
  output logic                  ready_b,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  claim,
  input  logic [ADDR_WIDTH-1:0] claim_addr,
  output logic                  busy_any,
  output logic                  claim_err,
  output logic [DATA_WIDTH-1:0] register_v0
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0]                 busy_q;
  logic                                claim_err_q;

  logic write_in_range, write_is_zero, write_ok;
  logic claim_in_range, claim_is_zero, claim_ok;
  logic claim_busy, claim_err_set;

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH compares without overflow.
  assign write_in_range = {1'b0, write_addr} < (ADDR_WIDTH+1)'(NUM_REGS);
  assign claim_in_range = {1'b0, claim_addr} < (ADDR_WIDTH+1)'(NUM_REGS);
  assign write_is_zero  = (ZERO_REG_EN != 0) && (write_addr == ADDR_WIDTH'(ZERO_REG));
  assign claim_is_zero  = (ZERO_REG_EN != 0) && (claim_addr == ADDR_WIDTH'(ZERO_REG));
  assign write_ok       = write && write_in_range && !write_is_zero;
  assign claim_ok       = claim && claim_in_range && !claim_is_zero;

  always_comb begin
    claim_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (claim_addr == ADDR_WIDTH'(i)) claim_busy = busy_q[i];
    end
  end

  assign claim_err_set = claim && (!claim_in_range || (claim_ok && claim_busy));

  // A same-index claim is applied after the write so it wins the busy bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q      <= '0;
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (write_ok && (write_addr == ADDR_WIDTH'(i))) begin
          regs_q[i] <= data_in;
          busy_q[i] <= 1'b0;
        end
        if (claim_ok && (claim_addr == ADDR_WIDTH'(i))) busy_q[i] <= 1'b1;
      end
      if (claim_err_set) claim_err_q <= 1'b1;
    end
  end

  reg_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG_EN(ZERO_REG_EN),
    .BYPASS_EN  (BYPASS_EN)
  ) u_port_a (
    .addr      (addr_a),
    .regs      (regs_q),
    .busy      (busy_q),
    .write_ok  (write_ok),
    .write_addr(write_addr),
    .data_in   (data_in),
    .data      (a),
    .ready     (ready_a)
  );

  reg_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG_EN(ZERO_REG_EN),
    .BYPASS_EN  (BYPASS_EN)
  ) u_port_b (
    .addr      (addr_b),
    .regs      (regs_q),
    .busy      (busy_q),
    .write_ok  (write_ok),
    .write_addr(write_addr),
    .data_in   (data_in),
    .data      (b),
    .ready     (ready_b)
  );

  assign busy_any    = |busy_q;
  assign claim_err   = claim_err_q;
  assign register_v0 = regs_q[V0_INDEX];

`ifdef REG_FILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && write_ok)
      $display("%0t reg_file_sb: write r%0d = 0x%h", $time, write_addr, data_in);
    if (reset && claim_err_set && !claim_err_q)
      $display("%0t reg_file_sb: claim_err on claim of r%0d", $time, claim_addr);
  end
`else
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a full 32-entry instance and a 16-entry instance
// with 5-bit indices, both driven by the same stimulus.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset, write, claim;
  logic [4:0]  addr_a, addr_b, write_addr, claim_addr;
  logic [31:0] data_in;

  logic [31:0] a32, b32, v032, a16, b16, v016;
  logic        ra32, rb32, ba32, ce32, ra16, rb16, ba16, ce16;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_file_sb dut32 (
    .clk(clk), .reset(reset), .addr_a(addr_a), .addr_b(addr_b),
    .a(a32), .b(b32), .ready_a(ra32), .ready_b(rb32),
    .write(write), .write_addr(write_addr), .data_in(data_in),
    .claim(claim), .claim_addr(claim_addr),
    .busy_any(ba32), .claim_err(ce32), .register_v0(v032)
  );

  reg_file_sb #(.NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .addr_a(addr_a), .addr_b(addr_b),
    .a(a16), .b(b16), .ready_a(ra16), .ready_b(rb16),
    .write(write), .write_addr(write_addr), .data_in(data_in),
    .claim(claim), .claim_addr(claim_addr),
    .busy_any(ba16), .claim_err(ce16), .register_v0(v016)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];
  bit          m_cerr [2];

  function automatic int nregs(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit write_legal(int k);
    return write && (write_addr != 5'd0) && (int'(write_addr) < nregs(k));
  endfunction

  function automatic logic [31:0] exp_data(int k, logic [4:0] ad);
    if (ad == 5'd0) return 32'h0;
    if (write_legal(k) && (write_addr == ad)) return data_in;
    if (int'(ad) >= nregs(k)) return 32'h0;
    return m_regs[k][ad];
  endfunction

  function automatic bit exp_ready(int k, logic [4:0] ad);
    if (ad == 5'd0) return 1'b1;
    if (write_legal(k) && (write_addr == ad)) return 1'b1;
    if (int'(ad) >= nregs(k)) return 1'b1;
    return !m_busy[k][ad];
  endfunction

  function automatic bit exp_busy_any(int k);
    for (int i = 0; i < 32; i++) if (m_busy[k][i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(int k);
    bit was_busy;
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = 32'h0;
        m_busy[k][i] = 1'b0;
      end
      m_cerr[k] = 1'b0;
    end else begin
      was_busy = m_busy[k][claim_addr];
      if (write_legal(k)) begin
        m_regs[k][write_addr] = data_in;
        m_busy[k][write_addr] = 1'b0;
      end
      if (claim) begin
        if (int'(claim_addr) >= nregs(k)) m_cerr[k] = 1'b1;
        else if (claim_addr != 5'd0) begin
          if (was_busy) m_cerr[k] = 1'b1;
          m_busy[k][claim_addr] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic check_model();
    chk32("m32_a", a32, exp_data(0, addr_a));
    chk32("m32_b", b32, exp_data(0, addr_b));
    chk1 ("m32_ready_a", ra32, exp_ready(0, addr_a));
    chk1 ("m32_ready_b", rb32, exp_ready(0, addr_b));
    chk1 ("m32_busy_any", ba32, exp_busy_any(0));
    chk1 ("m32_claim_err", ce32, m_cerr[0]);
    chk32("m32_v0", v032, m_regs[0][2]);
    chk32("m16_a", a16, exp_data(1, addr_a));
    chk32("m16_b", b16, exp_data(1, addr_b));
    chk1 ("m16_ready_a", ra16, exp_ready(1, addr_a));
    chk1 ("m16_ready_b", rb16, exp_ready(1, addr_b));
    chk1 ("m16_busy_any", ba16, exp_busy_any(1));
    chk1 ("m16_claim_err", ce16, m_cerr[1]);
    chk32("m16_v0", v016, m_regs[1][2]);
  endtask

  // Inputs change on the falling edge; outputs are sampled 2ns later.
  task automatic drive(bit rst_n, bit wr, logic [4:0] wa, logic [31:0] din,
                       bit cl, logic [4:0] ca, logic [4:0] aa, logic [4:0] ab);
    reset = rst_n; write = wr; write_addr = wa; data_in = din;
    claim = cl; claim_addr = ca; addr_a = aa; addr_b = ab;
    #2;
  endtask

  task automatic tick();
    check_model();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst_n;
    bit          wr;
    logic [4:0]  wa;
    logic [31:0] din;
    bit          cl;
    logic [4:0]  ca;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic [31:0] ea;
    bit          era;
    logic [31:0] eb;
    bit          erb;
    bit          ebusy;
    bit          ecerr;
    logic [31:0] ev0;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 5'd5,  32'h55,       1'b0, 5'd0, 5'd5, 5'd5, 32'h55,       1'b1, 32'h55,       1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd5,  32'h77,       1'b0, 5'd0, 5'd5, 5'd5, 32'h77,       1'b1, 32'h77,       1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5, 5'd3, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 5'd2,  32'hDEADBEEF, 1'b0, 5'd0, 5'd2, 5'd0, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd2, 5'd2, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[5]  = '{1'b1, 1'b1, 5'd0,  32'h1234,     1'b0, 5'd0, 5'd0, 5'd2, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[7]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd8, 5'd0, 5'd8, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd8, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[10] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd8, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd8, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[12] = '{1'b1, 1'b1, 5'd8,  32'h7,        1'b0, 5'd0, 5'd0, 5'd8, 32'h0,        1'b1, 32'h7,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd8, 32'h0,        1'b1, 32'h7,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[14] = '{1'b1, 1'b1, 5'd9,  32'h5,        1'b1, 5'd9, 5'd9, 5'd8, 32'h5,        1'b1, 32'h7,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[15] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd8, 32'h5,        1'b0, 32'h7,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[16] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9, 5'd8, 32'h5,        1'b0, 32'h7,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[17] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd8, 32'h5,        1'b0, 32'h7,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF};

    // Initial reset brings both instances and the model to a known state.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst_n, tbl[i].wr, tbl[i].wa, tbl[i].din,
            tbl[i].cl, tbl[i].ca, tbl[i].aa, tbl[i].ab);
      chk32($sformatf("vec%0d_a", i), a32, tbl[i].ea);
      chk1 ($sformatf("vec%0d_ready_a", i), ra32, tbl[i].era);
      chk32($sformatf("vec%0d_b", i), b32, tbl[i].eb);
      chk1 ($sformatf("vec%0d_ready_b", i), rb32, tbl[i].erb);
      chk1 ($sformatf("vec%0d_busy_any", i), ba32, tbl[i].ebusy);
      chk1 ($sformatf("vec%0d_claim_err", i), ce32, tbl[i].ecerr);
      chk32($sformatf("vec%0d_v0", i), v032, tbl[i].ev0);
      tick();
    end

    // claim_err stays set across idle cycles until reset.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd8);
      chk1("sticky_claim_err", ce32, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd8);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd8);
    chk1("reset_clears_err32", ce32, 1'b0);
    chk1("reset_clears_err16", ce16, 1'b0);
    chk1("reset_ready_a", ra32, 1'b1);
    chk32("reset_a", a32, 32'h0);
    tick();

    // Out-of-range index on the 16-entry instance: write ignored, claim flags error.
    drive(1'b1, 1'b1, 5'd20, 32'h9, 1'b0, 5'd0, 5'd20, 5'd0);
    chk32("oor16_bypass_a", a16, 32'h0);
    chk1 ("oor16_bypass_ready", ra16, 1'b1);
    chk32("inr32_bypass_a", a32, 32'h9);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd20, 5'd0);
    chk32("oor16_a", a16, 32'h0);
    chk32("inr32_a", a32, 32'h9);
    chk1 ("oor16_err_before", ce16, 1'b0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd0);
    chk1("oor16_claim_err", ce16, 1'b1);
    chk1("oor16_busy_any", ba16, 1'b0);
    chk1("inr32_claim_err", ce32, 1'b0);
    chk1("inr32_busy_any", ba32, 1'b1);
    chk1("inr32_ready_a", ra32, 1'b0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 40) != 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
